// File: rtl/dr32e_pkg.sv
// Shared dr32e definitions used by the data-memory responder: response record,
// SECDED(39,32) check-bit encoder and the stall LFSR tap mask.
package dr32e_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } dmem_resp_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] DMEM_LFSR_TAPS = 16'hB400;

    // Hamming(38,32) plus overall parity. Data bits occupy the non-power-of-two
    // codeword positions; the Hamming syndrome is the XOR of positions of set bits.
    function automatic logic [6:0] dr32e_secded39_enc(input logic [31:0] data);
        logic [5:0] syn;
        logic [5:0] pos;
        logic [4:0] di;
        syn = '0;
        di  = '0;
        for (pos = 6'd1; pos <= 6'd38; pos = pos + 6'd1) begin
            if ((pos & (pos - 6'd1)) != 6'd0) begin
                if (data[di]) begin
                    syn = syn ^ pos;
                end
                di = di + 5'd1;
            end
        end
        return {(^data) ^ (^syn), syn};
    endfunction

endpackage

// File: rtl/dr32e_dmem_resp_pipe.sv
// Fixed-latency response shift register; every stage advances each cycle.
module dr32e_dmem_resp_pipe
    import dr32e_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  dmem_resp_t resp_i,
    output dmem_resp_t resp_o
);

    localparam int unsigned RespW = $bits(dmem_resp_t);

    dmem_resp_t [Latency-1:0] stage_q;
    dmem_resp_t [Latency-1:0] stage_d;
    dmem_resp_t               head;

    // Idle slots are all-zero so rdata/err read as 0 whenever valid is low.
    always_comb begin
        head = '0;
        if (push_i) begin
            head       = resp_i;
            head.valid = 1'b1;
        end
        stage_d    = stage_q << RespW;
        stage_d[0] = head;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign resp_o = stage_q[Latency-1];

endmodule

// File: rtl/dr32e_dmem_responder.sv
// dr32e data-bus slave: word RAM with byte-enabled writes, range errors and a
// fixed-latency in-order response pipe. Optional random stall: DR32E_DMEM_RAND_STALL_EN.
module dr32e_dmem_responder
    import dr32e_pkg::*;
#(
    parameter bit          MemECC         = 1'b0,
    parameter int unsigned MemDataWidth   = MemECC ? 39 : 32,
    parameter int unsigned MemDepthWords  = 1024,
    parameter logic [31:0] AddrBase       = 32'h0000_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 1,
    parameter logic [15:0] StallSeed      = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    data_req_o,
    input  logic [31:0]             data_addr_o,
    input  logic                    data_we_o,
    input  logic [3:0]              data_be_o,
    input  logic [MemDataWidth-1:0] data_wdata_o,
    output logic                    data_gnt_i,
    output logic                    data_rvalid_i,
    output logic [MemDataWidth-1:0] data_rdata_i,
    output logic                    data_bus_err_i,
    output logic                    data_pmp_err_i
);

    localparam int unsigned IdxW      = $clog2(MemDepthWords);
    localparam logic [32:0] SpanBytes = 33'(MemDepthWords) << 2;

    logic [31:0]     mem [MemDepthWords];
    logic            stall;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      outstanding;
    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            hs;
    logic [31:0]     be_mask;
    dmem_resp_t      resp_in;
    dmem_resp_t      resp_out;

`ifdef DR32E_DMEM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & DMEM_LFSR_TAPS)};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= StallSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    logic unused_stall_seed;
    assign unused_stall_seed = ^StallSeed;
    assign stall             = 1'b0;
`endif

    // A response retiring this cycle frees its slot immediately, so a full
    // pipe can still accept one request per cycle.
    always_comb begin
        offset      = data_addr_o - AddrBase;
        in_range    = (data_addr_o >= AddrBase) && ({1'b0, offset} < SpanBytes);
        idx         = offset[IdxW+1:2];
        outstanding = cnt_q - {2'b00, resp_out.valid};
        data_gnt_i  = data_req_o & ~stall & (outstanding < 3'(MaxOutstanding));
        hs          = data_req_o & data_gnt_i;
        cnt_d       = cnt_q + {2'b00, hs} - {2'b00, resp_out.valid};
        be_mask     = {{8{data_be_o[3]}}, {8{data_be_o[2]}},
                       {8{data_be_o[1]}}, {8{data_be_o[0]}}};
        resp_in       = '0;
        resp_in.valid = 1'b1;
        resp_in.err   = ~in_range;
        if (in_range && !data_we_o) begin
            resp_in.rdata = mem[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs && data_we_o && in_range) begin
            mem[idx] <= (mem[idx] & ~be_mask) | (data_wdata_o[31:0] & be_mask);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    dr32e_dmem_resp_pipe #(
        .Latency (RespLatency)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (hs),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    assign data_rvalid_i  = resp_out.valid;
    assign data_bus_err_i = resp_out.err;
    assign data_pmp_err_i = 1'b0;

    generate
        if (MemECC) begin : g_ecc
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^data_wdata_o[MemDataWidth-1:32];
            assign data_rdata_i    = {dr32e_secded39_enc(resp_out.rdata), resp_out.rdata};
        end else begin : g_no_ecc
            assign data_rdata_i = resp_out.rdata;
        end
    endgenerate

endmodule

// File: tb/tb_dr32e_dmem_responder.sv
// Directed bench: four responder instances cover latency/outstanding configurations.
module tb_dr32e_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic        req_a, req_b, req_c, req_d;
    logic        gnt_a, gnt_b, gnt_c, gnt_d;
    logic        rv_a, rv_b, rv_c, rv_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;
    logic        be_a, be_b, be_c, be_d;
    logic        pe_a, pe_b, pe_c, pe_d;

    int checks   = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    dr32e_dmem_responder #(.RespLatency(1), .MaxOutstanding(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .data_req_o(req_a), .data_addr_o(addr),
        .data_we_o(we), .data_be_o(be), .data_wdata_o(wdata), .data_gnt_i(gnt_a),
        .data_rvalid_i(rv_a), .data_rdata_i(rd_a), .data_bus_err_i(be_a),
        .data_pmp_err_i(pe_a));

    dr32e_dmem_responder #(.RespLatency(3), .MaxOutstanding(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .data_req_o(req_b), .data_addr_o(addr),
        .data_we_o(we), .data_be_o(be), .data_wdata_o(wdata), .data_gnt_i(gnt_b),
        .data_rvalid_i(rv_b), .data_rdata_i(rd_b), .data_bus_err_i(be_b),
        .data_pmp_err_i(pe_b));

    dr32e_dmem_responder #(.RespLatency(3), .MaxOutstanding(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .data_req_o(req_c), .data_addr_o(addr),
        .data_we_o(we), .data_be_o(be), .data_wdata_o(wdata), .data_gnt_i(gnt_c),
        .data_rvalid_i(rv_c), .data_rdata_i(rd_c), .data_bus_err_i(be_c),
        .data_pmp_err_i(pe_c));

    dr32e_dmem_responder #(.RespLatency(4), .MaxOutstanding(1)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .data_req_o(req_d), .data_addr_o(addr),
        .data_we_o(we), .data_be_o(be), .data_wdata_o(wdata), .data_gnt_i(gnt_d),
        .data_rvalid_i(rv_d), .data_rdata_i(rd_d), .data_bus_err_i(be_d),
        .data_pmp_err_i(pe_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on instance A (latency 1): grant now, response next cycle.
    task automatic xa(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
        req_a = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        #1;
        chk({tag, "_gnt"}, {31'b0, gnt_a}, 32'd1);
        @(negedge clk);
        chk({tag, "_rvalid"}, {31'b0, rv_a}, 32'd1);
        chk({tag, "_err"}, {31'b0, be_a}, {31'b0, exp_err});
        chk({tag, "_rdata"}, rd_a, exp_rd);
        req_a = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        req_c = 1'b0;
        req_d = 1'b0;
        addr  = '0;
        wdata = '0;
        we    = 1'b0;
        be    = 4'h0;
        @(negedge clk);
        @(negedge clk);

        chk("rst_rvalid", {31'b0, rv_a}, 32'd0);
        chk("rst_rdata", rd_a, 32'd0);
        chk("rst_berr", {31'b0, be_a}, 32'd0);
        chk("rst_pmp", {31'b0, pe_a}, 32'd0);
        chk("rst_gnt_idle", {31'b0, gnt_a}, 32'd0);
        req_a = 1'b1;
        #1;
        chk("rst_gnt_req", {31'b0, gnt_a}, 32'd1);
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back, plus a read with no byte enables.
        xa(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, "wr10");
        xa(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, "rd10");
        xa(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, "rd10_be0");
        @(negedge clk);
        chk("a_idle_rvalid", {31'b0, rv_a}, 32'd0);

        // Partial byte-enable write.
        xa(1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, "pre20");
        xa(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, "be20");
        xa(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, "rd20");

        // Range edges and out-of-range accesses that would alias if unchecked.
        xa(1'b1, 32'h0, 4'hF, 32'h01234567, 32'h0, 1'b0, "pre00");
        xa(1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, "wrFFC");
        xa(1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b1, "oor_rd1000");
        xa(1'b1, 32'h2000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, "oor_wr2000");
        xa(1'b1, 32'h1FFC, 4'hF, 32'h55555555, 32'h0, 1'b1, "oor_wr1FFC");
        xa(1'b0, 32'h0, 4'hF, 32'h0, 32'h01234567, 1'b0, "rd00_after_oor");
        xa(1'b0, 32'hFFC, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, "rdFFC_after_oor");
        xa(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, "rd10_after_oor");
        @(negedge clk);

        // Instance B: back-to-back writes then reads, latency 3.
        for (int i = 0; i < 8; i++) begin
            req_b = (i < 4);
            we    = 1'b1;
            addr  = 32'(i * 4);
            be    = 4'hF;
            wdata = 32'hB0B0_0000 + 32'(i);
            #1;
            chk($sformatf("b_wr_gnt%0d", i), {31'b0, gnt_b}, {31'b0, (i < 4)});
            chk($sformatf("b_wr_rv%0d", i), {31'b0, rv_b}, {31'b0, (i >= 3 && i <= 6)});
            if (i >= 3 && i <= 6) begin
                chk($sformatf("b_wr_rd%0d", i), rd_b, 32'h0);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            req_b = (i < 4);
            we    = 1'b0;
            addr  = 32'(i * 4);
            #1;
            chk($sformatf("b_rd_gnt%0d", i), {31'b0, gnt_b}, {31'b0, (i < 4)});
            chk($sformatf("b_rd_rv%0d", i), {31'b0, rv_b}, {31'b0, (i >= 3 && i <= 6)});
            if (i >= 3 && i <= 6) begin
                chk($sformatf("b_rd_data%0d", i), rd_b, 32'hB0B0_0000 + 32'(i - 3));
                chk($sformatf("b_rd_err%0d", i), {31'b0, be_b}, 32'd0);
            end
            @(negedge clk);
        end

        // Instance C: request held high, one slot, latency 3.
        req_c = 1'b1;
        we    = 1'b1;
        addr  = 32'h0;
        be    = 4'hF;
        wdata = 32'h5;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("c_gnt%0d", i), {31'b0, gnt_c}, {31'b0, (i % 3 == 0)});
            chk($sformatf("c_rv%0d", i), {31'b0, rv_c}, {31'b0, (i >= 3 && i % 3 == 0)});
            @(negedge clk);
        end
        req_c = 1'b0;
        repeat (4) @(negedge clk);

        // Instance D: reset while a read is in flight, latency 4.
        req_d = 1'b1;
        we    = 1'b0;
        addr  = 32'h10;
        #1;
        chk("d_gnt_first", {31'b0, gnt_d}, 32'd1);
        @(negedge clk);
        req_d = 1'b0;
        chk("d_rv_before_rst", {31'b0, rv_d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("d_rv_in_rst", {31'b0, rv_d}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("d_rv_dropped%0d", i), {31'b0, rv_d}, 32'd0);
            @(negedge clk);
        end
        req_d = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("d_post_gnt%0d", k), {31'b0, gnt_d}, {31'b0, (k == 0 || k == 4)});
            chk($sformatf("d_post_rv%0d", k), {31'b0, rv_d}, {31'b0, (k == 4)});
            @(negedge clk);
        end
        req_d = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dr32e_dmem_responder.md
# dr32e_dmem_responder

Synthesizable data-memory responder for the dr32e LSU data interface. It answers `data_req_o`/`data_gnt_i`/`data_rvalid_i` transactions, holds a word-organised RAM, applies byte-enabled writes and reports out-of-range accesses as bus errors. It is the slave end of the data bus: it is instantiated in LSU-level testbenches and in the dr32e simulation top, and it feeds the same signals the LSU monitor observes.

## Interface
Parameters:
- `MemECC`, 1'b0: append 7 SECDED check bits to `data_rdata_i`.
- `MemDataWidth`, `MemECC ? 39 : 32`: bus data width.
- `MemDepthWords`, 1024: RAM depth in 32-bit words; power of two.
- `AddrBase`, 32'h0000_0000: base byte address; word-aligned.
- `RespLatency`, 1: cycles from handshake to `data_rvalid_i`; legal range 1..4.
- `MaxOutstanding`, 1: maximum granted-but-unanswered requests; legal range 1..`RespLatency`.
- `StallSeed`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `data_req_o` in 1: request from the LSU.
- `data_addr_o` in 32: byte address; bits [1:0] are ignored.
- `data_we_o` in 1: 1 = write, 0 = read.
- `data_be_o` in 4: byte enables.
- `data_wdata_o` in MemDataWidth: write data; bits above 31 are ignored.
- `data_gnt_i` out 1: grant (combinational).
- `data_rvalid_i` out 1: response valid, asserted for one cycle per granted request.
- `data_rdata_i` out MemDataWidth: read data.
- `data_bus_err_i` out 1: error flag, qualified by `data_rvalid_i`.
- `data_pmp_err_i` out 1: tied to 0.

## Operation
- Grant: `data_gnt_i = data_req_o & ~stall & (outstanding < MaxOutstanding)`.
- Handshake (`data_req_o & data_gnt_i`):
  - Word index = `(data_addr_o - AddrBase) >> 2`.
  - `in_range` = address lies in `[AddrBase, AddrBase + 4*MemDepthWords)`.
  - Write and in range: each byte i with `data_be_o[i]=1` is written at this edge; other bytes are unchanged.
  - Read and in range: the full 32-bit word is sampled at this edge. `data_be_o` does not mask read data.
  - Out of range: no RAM access; the response carries error=1 and rdata=0.
- Response pipeline:
  - Shift register with `RespLatency` stages; each stage holds {valid, err, rdata[31:0]}.
  - Stage 0 loads at the handshake edge.
  - All stages shift every cycle; there is no backpressure.
  - `data_rvalid_i` = last-stage valid.
  - `data_rdata_i[31:0]` = last-stage rdata. It is 0 for writes and for error responses.
- Outstanding counter:
  - Increments on handshake and decrements on `data_rvalid_i`.
  - Handshake and `data_rvalid_i` in the same cycle leave it unchanged.
  - A counter value of `MaxOutstanding` holds grant low until a response retires.
- Ordering:
  - Responses return in request order.
  - A read granted in the cycle after a write to the same word returns the new data.
- ECC (`MemECC=1`): `data_rdata_i[38:32]` = SECDED check bits of `data_rdata_i[31:0]`, computed combinationally at the output. Error responses also carry the check bits of 0.

## Timing
- Reset values: `data_gnt_i` follows its equation with stall=0 and outstanding=0. `data_rvalid_i`=0, `data_rdata_i`=0, `data_bus_err_i`=0, `data_pmp_err_i`=0.
- Reset clears pipeline valids and the counter, and loads the LFSR with `StallSeed`. RAM contents are not reset.
- Reset asserted mid-transaction drops all in-flight responses. After reset releases, no `data_rvalid_i` appears for them.
- Latency: handshake at edge N gives `data_rvalid_i` high in the cycle after edge N+RespLatency-1. With `RespLatency=1`, rvalid is high in the cycle immediately after the grant cycle.
- Throughput: with `MaxOutstanding = RespLatency` and no stall, one transaction per cycle.

## Configuration
- `DR32E_DMEM_RAND_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - `stall = (lfsr[1:0] == 2'b00)`, which withholds grant about 25% of cycles.
  - A stalled request is not consumed; the LSU keeps it asserted.
- Undefined: the LFSR is not built and stall is constant 0.

## Structure
- Shared package `dr32e_pkg` holds:
  - `dmem_resp_t` struct {valid, err, rdata[31:0]}.
  - SECDED encode function `dr32e_secded39_enc`.
  - LFSR tap constant `DMEM_LFSR_TAPS`.
- Sub-module `dr32e_dmem_resp_pipe` is the parameterised latency shift register, with ports `clk_i`, `rst_ni`, `push_i`, `resp_i`, `resp_o`.
- The RAM is an inferred array in the top module.

## Test plan
- Write then read, `RespLatency=1`, `MaxOutstanding=1`:
  - Write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10.
  - Expect rdata=32'hDEADBEEF, err=0, rvalid exactly one cycle after each grant.
- Byte enables:
  - Preload 0x20 = 32'h11223344, write 32'hAABBCCDD with be=4'b0101, then read.
  - Expect 32'h11BB33DD.
- Out of range, `MemDepthWords=1024`:
  - Read 0x1000 and write 0x2000.
  - Expect err=1 and rdata=0 for both; RAM checksum unchanged.
- Pipelining, `RespLatency=3`, `MaxOutstanding=3`:
  - Issue 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC.
  - Expect all granted consecutively; responses arrive in order on consecutive cycles, starting 3 cycles after the first grant.
- Outstanding limit, `RespLatency=3`, `MaxOutstanding=1`:
  - Hold req high.
  - Expect grant every 3rd cycle, never 2 outstanding; rvalid and the next grant coincide.
- Reset mid-flight, `RespLatency=4`:
  - Grant a read, then pulse `rst_ni` low 2 cycles later.
  - Expect no rvalid afterwards and the counter back at 0.
  - With `DR32E_DMEM_RAND_STALL_EN` defined, the stall sequence restarts from `StallSeed`.
